// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: state encoding, strobe bundle, per-state strobe decode.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T0     = 3'd1,
    T1     = 3'd2,
    MWAIT  = 3'd3,
    T2     = 3'd4,
    EXEC   = 3'd5,
    HALTED = 3'd6,
    ERROR  = 3'd7
  } state_t;

  // Datapath load / bus-enable strobes, MSB first in fetch-step order.
  typedef struct packed {
    logic pc_out_en;
    logic mar_load;
    logic inc_pc;
    logic z_load;
    logic zlow_out_en;
    logic pc_load;
    logic mem_read;
    logic mdr_load;
    logic mdr_out_en;
    logic ir_load;
  } strobe_t;

  localparam strobe_t STB_NONE  = strobe_t'(10'b0000_0000_00);
  localparam strobe_t STB_T0    = strobe_t'(10'b1111_0000_00);
  localparam strobe_t STB_T1    = strobe_t'(10'b0000_1111_00);
  localparam strobe_t STB_MWAIT = strobe_t'(10'b0000_0011_00);
  localparam strobe_t STB_T2    = strobe_t'(10'b0000_0000_11);

  // Moore decode: only one bus driver (pc_out_en, zlow_out_en, mdr_out_en) is ever set.
  function automatic strobe_t state_strobes(input state_t s);
    case (s)
      T0:      return STB_T0;
      T1:      return STB_T1;
      MWAIT:   return STB_MWAIT;
      T2:      return STB_T2;
      default: return STB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/handshake bundle between the fetch sequencer and the datapath, memory and execute control.
// Latency: none, wiring only.
// Backpressure: memory stalls via mem_ready; execute releases the sequencer via exec_done.
interface fetch_sequencer_if;
  logic        start;
  logic        exec_done;
  logic        halt;
  logic        mem_ready;
  logic        pc_out_en;
  logic        mar_load;
  logic        inc_pc;
  logic        z_load;
  logic        zlow_out_en;
  logic        pc_load;
  logic        mem_read;
  logic        mdr_load;
  logic        mdr_out_en;
  logic        ir_load;
  logic        fetch_done;
  logic        busy;
  logic        mem_timeout;
  logic [31:0] fetch_count;

  modport master (
    input  start, exec_done, halt, mem_ready,
    output pc_out_en, mar_load, inc_pc, z_load, zlow_out_en, pc_load,
           mem_read, mdr_load, mdr_out_en, ir_load,
           fetch_done, busy, mem_timeout, fetch_count
  );

  modport slave (
    output start, exec_done, halt, mem_ready,
    input  pc_out_en, mar_load, inc_pc, z_load, zlow_out_en, pc_load,
           mem_read, mdr_load, mdr_out_en, ir_load,
           fetch_done, busy, mem_timeout, fetch_count
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Memory-wait counter: clear, count-enable, terminal count at MEM_TIMEOUT-1.
// Latency: count updates one cycle after enable; tc is combinational from the count.
// Backpressure: none; the counter holds its value when neither clear nor enable is set.
module fetch_timeout_ctr #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [TO_W-1:0] cnt_q;

  // Clear has priority so the first wait cycle always starts from zero.
  always_ff @(posedge clk) begin
    if (reset)       cnt_q <= '0;
    else if (clear)  cnt_q <= '0;
    else if (enable) cnt_q <= cnt_q + 1'b1;
  end

  assign tc = (cnt_q == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: T0/T1/T2 strobe sequencing with memory wait, exec handoff, halt and timeout error.
// Latency: start -> T0 next cycle; fetch_done 3 cycles after start with immediate mem_ready.
// Backpressure: stalls in MWAIT on mem_ready, in EXEC on exec_done. FETCH_SEQ_PERF_EN enables fetch_count.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.master   bus
);

  state_t  state_q, state_d;
  strobe_t stb;
  logic    to_tc;

  fetch_timeout_ctr #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_to_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == T1),
    .enable (state_q == MWAIT),
    .tc     (to_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; HALTED and ERROR are only left through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.halt)       state_d = HALTED;
        else if (bus.start) state_d = T0;
      end
      T0:    state_d = T1;
      T1:    state_d = bus.mem_ready ? T2 : MWAIT;
      MWAIT: begin
        if (bus.mem_ready) state_d = T2;
        else if (to_tc)    state_d = ERROR;
      end
      T2:    state_d = EXEC;
      EXEC: begin
        if (bus.exec_done) state_d = bus.halt ? HALTED : T0;
      end
      HALTED:  state_d = HALTED;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  assign stb             = state_strobes(state_q);
  assign bus.pc_out_en   = stb.pc_out_en;
  assign bus.mar_load    = stb.mar_load;
  assign bus.inc_pc      = stb.inc_pc;
  assign bus.z_load      = stb.z_load;
  assign bus.zlow_out_en = stb.zlow_out_en;
  assign bus.pc_load     = stb.pc_load;
  assign bus.mem_read    = stb.mem_read;
  assign bus.mdr_load    = stb.mdr_load;
  assign bus.mdr_out_en  = stb.mdr_out_en;
  assign bus.ir_load     = stb.ir_load;
  assign bus.fetch_done  = (state_q == T2);
  assign bus.busy        = (state_q != IDLE) && (state_q != HALTED) && (state_q != ERROR);
  assign bus.mem_timeout = (state_q == ERROR);

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] fetch_count_q;

  // Completed-fetch counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset)              fetch_count_q <= '0;
    else if (state_q == T2) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign bus.fetch_count = fetch_count_q;
`else
  assign bus.fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a per-cycle expected-output scoreboard.
// Latency: each step pushes the expected post-edge outputs, then pops and compares 1 time unit after the edge.
// Backpressure: mem_ready and exec_done are driven directly by the stimulus sequence.
module tb_fetch_sequencer;

  localparam int MEM_TIMEOUT = 4;
  localparam int TO_W        = 8;
`ifdef FETCH_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector: {pc_out_en, mar_load, inc_pc, z_load, zlow_out_en, pc_load,
  //                 mem_read, mdr_load, mdr_out_en, ir_load, fetch_done, busy, mem_timeout}
  localparam logic [12:0] E_IDLE = 13'b0000_0000_00_0_0_0;
  localparam logic [12:0] E_T0   = 13'b1111_0000_00_0_1_0;
  localparam logic [12:0] E_T1   = 13'b0000_1111_00_0_1_0;
  localparam logic [12:0] E_MW   = 13'b0000_0011_00_0_1_0;
  localparam logic [12:0] E_T2   = 13'b0000_0000_11_1_1_0;
  localparam logic [12:0] E_EX   = 13'b0000_0000_00_0_1_0;
  localparam logic [12:0] E_HALT = 13'b0000_0000_00_0_0_0;
  localparam logic [12:0] E_ERR  = 13'b0000_0000_00_0_0_1;

  typedef struct packed {
    logic [12:0] vec;
    logic [31:0] fc;
  } exp_t;

  logic clk;
  logic reset;
  fetch_sequencer_if sif ();

  fetch_sequencer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  logic [31:0] exp_fc = '0;
  logic        prev_fd = 1'b0;

  function automatic logic [12:0] obs_vec();
    return {sif.pc_out_en, sif.mar_load, sif.inc_pc, sif.z_load, sif.zlow_out_en,
            sif.pc_load, sif.mem_read, sif.mdr_load, sif.mdr_out_en, sif.ir_load,
            sif.fetch_done, sif.busy, sif.mem_timeout};
  endfunction

  // Push expected outputs for the coming edge, advance one cycle, pop and compare.
  task automatic step(input logic [12:0] v, input string tag);
    exp_t e;
    logic [12:0] ov;
    if (reset)                exp_fc = '0;
    else if (PERF && prev_fd) exp_fc = exp_fc + 32'd1;
    prev_fd = v[2];
    e.vec = v;
    e.fc  = exp_fc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e  = sb_q.pop_front();
    ov = obs_vec();
    checks++;
    assert (ov === e.vec) passed++;
    else begin
      fails++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, ov, e.vec);
    end
    checks++;
    assert (sif.fetch_count === e.fc) passed++;
    else begin
      fails++;
      $error("FAIL %s fetch_count observed=%0d expected=%0d", tag, sif.fetch_count, e.fc);
    end
  endtask

  initial begin
    reset         = 1'b1;
    sif.start     = 1'b0;
    sif.exec_done = 1'b0;
    sif.halt      = 1'b0;
    sif.mem_ready = 1'b0;

    // Reset state.
    step(E_IDLE, "rst0");
    step(E_IDLE, "rst1");
    reset = 1'b0;

    // halt beats start in IDLE; HALTED ignores start.
    sif.halt = 1'b1; sif.start = 1'b1;
    step(E_HALT, "idle_halt_prio");
    sif.halt = 1'b0;
    step(E_HALT, "halted_sticky");
    sif.start = 1'b0;
    reset = 1'b1;
    step(E_IDLE, "halt_reset");
    reset = 1'b0;

    // Basic fetch with immediate mem_ready.
    sif.start = 1'b1; sif.mem_ready = 1'b1;
    step(E_T0, "basic_t0");
    sif.start = 1'b0;
    step(E_T1, "basic_t1");
    step(E_T2, "basic_t2");
    step(E_EX, "basic_exec");

    // halt alone holds in EXEC.
    sif.halt = 1'b1;
    step(E_EX, "exec_halt_alone0");
    step(E_EX, "exec_halt_alone1");
    sif.halt = 1'b0;

    // Refetch with three memory wait cycles.
    sif.exec_done = 1'b1; sif.mem_ready = 1'b0;
    step(E_T0, "wait_t0");
    sif.exec_done = 1'b0;
    step(E_T1, "wait_t1");
    step(E_MW, "wait_mw1");
    step(E_MW, "wait_mw2");
    step(E_MW, "wait_mw3");
    sif.mem_ready = 1'b1;
    step(E_T2, "wait_t2");
    sif.mem_ready = 1'b0;
    step(E_EX, "wait_exec");

    // exec_done with halt goes to HALTED, no new T0.
    sif.exec_done = 1'b1; sif.halt = 1'b1;
    step(E_HALT, "exec_done_halt");
    sif.exec_done = 1'b0; sif.halt = 1'b0; sif.start = 1'b1;
    step(E_HALT, "halted_no_t0");
    sif.start = 1'b0;

    // Memory timeout into ERROR.
    reset = 1'b1;
    step(E_IDLE, "to_reset");
    reset = 1'b0;
    sif.start = 1'b1;
    step(E_T0, "to_t0");
    sif.start = 1'b0;
    step(E_T1, "to_t1");
    for (int i = 0; i < MEM_TIMEOUT; i++) step(E_MW, "to_mwait");
    step(E_ERR, "to_error");
    for (int i = 0; i < 20; i++) begin
      sif.mem_ready = i[0];
      sif.start     = i[1];
      sif.exec_done = i[2];
      step(E_ERR, "to_error_hold");
    end
    sif.mem_ready = 1'b0; sif.start = 1'b0; sif.exec_done = 1'b0;
    reset = 1'b1;
    step(E_IDLE, "to_cleared");
    reset = 1'b0;

    // Reset during MWAIT, then a clean fetch.
    sif.start = 1'b1;
    step(E_T0, "mid_t0");
    sif.start = 1'b0;
    step(E_T1, "mid_t1");
    step(E_MW, "mid_mw");
    reset = 1'b1;
    step(E_IDLE, "mid_reset");
    reset = 1'b0;
    sif.start = 1'b1; sif.mem_ready = 1'b1;
    step(E_T0, "clean_t0");
    sif.start = 1'b0;
    step(E_T1, "clean_t1");
    step(E_T2, "clean_t2");
    step(E_EX, "clean_exec");

    // Five back-to-back fetch/exec loops from a fresh reset.
    reset = 1'b1;
    step(E_IDLE, "loop_reset");
    reset = 1'b0;
    sif.start = 1'b1;
    step(E_T0, "loop_t0");
    sif.start = 1'b0;
    step(E_T1, "loop_t1");
    step(E_T2, "loop_t2");
    step(E_EX, "loop_exec");
    for (int k = 0; k < 4; k++) begin
      sif.exec_done = 1'b1;
      step(E_T0, "loop_t0");
      sif.exec_done = 1'b0;
      step(E_T1, "loop_t1");
      step(E_T2, "loop_t2");
      step(E_EX, "loop_exec");
    end
    step(E_EX, "loop_final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Initiator-side control for the datapath's PC, IR, MAR, MDR and Z registers. It drives their load and bus-enable strobes through the three-step instruction fetch: T0 PCout/MARin/IncPC/Zin, T1 Zlowout/PCin/Read/MDRin, T2 MDRout/IRin.
- It waits on a memory-ready handshake during the read.
- It hands off to execute control with a one-cycle fetch_done pulse, then waits for exec_done before starting the next fetch.

Parameters:
- MEM_TIMEOUT, 15: maximum memory wait cycles before the error state; legal range 1..255.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begins fetching from IDLE
- exec_done  in  1  execute phase complete; one-cycle pulse
- halt  in  1  stop after the current instruction
- mem_ready  in  1  memory read data valid this cycle
- pc_out_en  out  1  PC drives bus
- mar_load  out  1  MAR loads from bus
- inc_pc  out  1  ALU selects PC+1
- z_load  out  1  Z register loads
- zlow_out_en  out  1  Zlow drives bus
- pc_load  out  1  PC loads from bus
- mem_read  out  1  memory read request
- mdr_load  out  1  MDR loads memory data
- mdr_out_en  out  1  MDR drives bus
- ir_load  out  1  IR loads from bus
- fetch_done  out  1  one-cycle pulse, IR valid next cycle
- busy  out  1  high in every state except IDLE, HALTED and ERROR
- mem_timeout  out  1  sticky error flag
- fetch_count  out  32  completed fetches (optional feature)

Behaviour:
- The only clock is clk. reset is synchronous and active-high.
- Reset state is IDLE. In IDLE, all strobes, fetch_done, busy, mem_timeout and fetch_count are 0.
- Moore outputs: every strobe is decoded from the state register only; there is no input-to-output combinational path.
- At most one bus driver is enabled in any state: pc_out_en, zlow_out_en or mdr_out_en.
- States and transitions:
  - IDLE: halt -> HALTED (halt has priority over start); else start -> T0; else stay.
  - T0: pc_out_en, mar_load, inc_pc, z_load. Always -> T1.
  - T1: zlow_out_en, pc_load, mem_read, mdr_load. mem_ready=1 -> T2; else -> MWAIT with the timeout counter cleared to 0.
  - MWAIT: mem_read and mdr_load held; pc_load and zlow_out_en low, so the PC is not reloaded.
    - mem_ready=1 -> T2.
    - Else the counter increments; when the counter equals MEM_TIMEOUT-1 and mem_ready=0 -> ERROR.
    - With mem_ready held low, MWAIT lasts exactly MEM_TIMEOUT cycles.
  - T2: mdr_out_en, ir_load, fetch_done. Always -> EXEC.
  - EXEC: all strobes low, busy=1.
    - exec_done with halt -> HALTED.
    - exec_done without halt -> T0.
    - Otherwise stay in EXEC. halt alone does not leave EXEC.
  - HALTED: busy=0, all strobes low. Exits only on reset.
  - ERROR: mem_timeout=1, busy=0, all strobes low. Exits only on reset.
- Latency: start in cycle n gives T0 in cycle n+1. With immediate mem_ready, fetch_done is asserted in cycle n+3.
- mem_ready, start and exec_done are ignored in any state where they are not listed above.
- Reset mid-fetch: the next state is IDLE and all outputs are 0 on the following edge. A partially updated PC is not rolled back.
- The counter is only meaningful in MWAIT and is held otherwise.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- Defined: fetch_count increments (wrapping at 2^32) on every cycle fetch_done=1, and resets to 0.
- Undefined: the fetch_count port remains and is tied to 0; no counter flops are inferred.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum typedef: IDLE, T0, T1, MWAIT, T2, EXEC, HALTED, ERROR, encoded in 3 bits;
  - a packed struct typedef for the ten strobes;
  - the strobe constant for each state.
- Sub-module fetch_timeout_ctr: clear, enable, terminal-count output at MEM_TIMEOUT-1, TO_W-bit counter.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset, start=1 for one cycle, mem_ready=1 -> strobes T0, T1, T2 in cycles 1-3; fetch_done exactly once in cycle 3; EXEC in cycle 4.
- mem_ready held low 3 cycles after T1 -> exactly 3 MWAIT cycles with mem_read=1 and pc_load=0; T2 on the cycle after mem_ready rises.
- MEM_TIMEOUT=4, mem_ready held 0 -> ERROR after 4 MWAIT cycles; mem_timeout=1 and busy=0 held for 20+ cycles; cleared by reset.
- In EXEC, exec_done=1 with halt=1 in the same cycle -> HALTED next cycle, no new T0; halt alone in EXEC -> remains in EXEC.
- reset asserted during MWAIT -> IDLE and all outputs 0 after one edge; a subsequent start performs a clean fetch.
- With FETCH_SEQ_PERF_EN defined, 5 back-to-back fetch/exec_done loops -> fetch_count=5. Without the macro, fetch_count=0 throughout.
